wb_arbiter: RTL



---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_arbiter_if.sv | 25 ++
 rtl/wb_fifo.sv | 36 +++
 rtl/wb_arbiter.sv | 54 +++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, buffered-entry type and zero-register constant for the write-back path
package wb_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbEntry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipe, long-unit and register-file write-port signals of the write-back arbiter
interface wb_arbiter_if;
  import wb_pkg::*;
  logic PipeWriteEnable;
  logic [ADDR_W-1:0] PipeWriteAddr;
  logic [DATA_W-1:0] PipeWriteData;
  logic ExcStopIn;
  logic LongValid;
  logic [ADDR_W-1:0] LongAddr;
  logic [DATA_W-1:0] LongData;
  logic LongReady;
  logic RdWriteEnable;
  logic [ADDR_W-1:0] RdWriteAddr;
  logic [DATA_W-1:0] RdWriteData;
  logic ExcStopRegfile;
  logic WbStall;
  modport master (
    output PipeWriteEnable, PipeWriteAddr, PipeWriteData, ExcStopIn, LongValid, LongAddr, LongData,
    input  LongReady, RdWriteEnable, RdWriteAddr, RdWriteData, ExcStopRegfile, WbStall
  );
  modport slave (
    input  PipeWriteEnable, PipeWriteAddr, PipeWriteData, ExcStopIn, LongValid, LongAddr, LongData,
    output LongReady, RdWriteEnable, RdWriteAddr, RdWriteData, ExcStopRegfile, WbStall
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with combinational head; reset discards contents by clearing pointers
module wb_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic push,
  input  logic pop,
  input  T din,
  output T head,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  assign head = mem[rdPtr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge Clk) if (push) mem[wrPtr] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges MEM/WB writes with buffered long-unit results onto the register-file write port,
// forcing a one-cycle WbStall when a buffered result has waited STARVE_MAX cycles
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic Clk,
  input logic Rst,
  wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  wbEntry_t longIn, head;
  logic full, empty, push, pop, pipeBusy, stallQ, stall;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  assign longIn.addr = bus.LongAddr;
  assign longIn.data = bus.LongData;
  assign stall = Rst && stallQ;
  assign pipeBusy = Rst && bus.PipeWriteEnable && bus.PipeWriteAddr != ZERO_REG && !bus.ExcStopIn && !stall;
  assign pop = Rst && !empty && !pipeBusy;
  assign bus.LongReady = Rst && count != CW'(FIFO_DEPTH);
  // x0 results are handshaken but never buffered
  assign push = Rst && bus.LongValid && !full && bus.LongAddr != ZERO_REG;
  wb_fifo #(.T(wbEntry_t), .DEPTH(FIFO_DEPTH)) fifo (
    .Clk(Clk),
    .Rst(Rst),
    .push(push),
    .pop(pop),
    .din(longIn),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.RdWriteEnable = pipeBusy || pop;
  assign bus.RdWriteAddr = pipeBusy ? bus.PipeWriteAddr : pop ? head.addr : '0;
  assign bus.RdWriteData = pipeBusy ? bus.PipeWriteData : pop ? head.data : '0;
  assign bus.ExcStopRegfile = Rst && bus.ExcStopIn && !stall;
  assign bus.WbStall = stall;
  // a head that has sat at the limit without being served steals the next cycle
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      starve <= '0;
      stallQ <= 1'b0;
    end else begin
      starve <= (pop || empty) ? '0 : starve == STARVE_LIM ? starve : starve + 1'b1;
      stallQ <= starve == STARVE_LIM && !pop;
    end
  end
endmodule
